// File: rtl/regbank_pkg.sv
// regbank_pkg: shared widths, register count and zero-register index for the register file
package regbank_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/regbank_read_port.sv
// regbank_read_port: one combinational read port with zero-index check and write-through bypass
// Ports: read_reg_i index, reg_write_i/write_reg_i/write_data_i live write for bypass,
//        regs_i flattened register contents (entry 0 unused), read_data_o result.
module regbank_read_port
  import regbank_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
) (
  input  logic [AW-1:0]              read_reg_i,
  input  logic                       reg_write_i,
  input  logic [AW-1:0]              write_reg_i,
  input  logic [DW-1:0]              write_data_i,
  input  logic [2**AW-1:0][DW-1:0]   regs_i,
  output logic [DW-1:0]              read_data_o
);
  // Bypass is deliberately not gated by reset: the write being presented is forwarded as-is.
  assign read_data_o = (read_reg_i == AW'(ZERO_REG)) ? '0 :
                       (reg_write_i && write_reg_i == read_reg_i) ? write_data_i :
                       regs_i[read_reg_i];
endmodule

// File: rtl/regbank_register_file.sv
// regbank_register_file: 2-read/1-write register file with hardwired zero register and write bypass
// Ports: clock, reset (async active-low), regWrite/writeReg/writeData write port,
//        readReg1/readReg2 indices, readData1/readData2 combinational read data.
module regbank_register_file
  import regbank_pkg::*;
#(
  parameter int DATA_WIDTH = regbank_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regbank_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  // Register 0 has no storage; the array covers indices 1..DEPTH-1 only.
  logic [DEPTH-1:1][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_all;
  assign regs_all = {regs_q, {DATA_WIDTH{1'b0}}};
  always_comb begin
    regs_d = regs_q;
    if (regWrite && writeReg != ADDR_WIDTH'(ZERO_REG)) regs_d[writeReg] = writeData;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) regs_q <= '0;
    else regs_q <= regs_d;
  regbank_read_port #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_rp1 (
    .read_reg_i   (readReg1),
    .reg_write_i  (regWrite),
    .write_reg_i  (writeReg),
    .write_data_i (writeData),
    .regs_i       (regs_all),
    .read_data_o  (readData1)
  );
  regbank_read_port #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_rp2 (
    .read_reg_i   (readReg2),
    .reg_write_i  (regWrite),
    .write_reg_i  (writeReg),
    .write_data_i (writeData),
    .regs_i       (regs_all),
    .read_data_o  (readData2)
  );
endmodule

// File: tb/tb_regbank_register_file.sv
// tb_regbank_register_file: vector table, directed corner cases and random stimulus vs array model
module tb_regbank_register_file;
  logic        clock = 0, reset = 0, regWrite = 0;
  logic [4:0]  readReg1 = 0, readReg2 = 0, writeReg = 0;
  logic [31:0] writeData = 0;
  logic [31:0] readData1, readData2;
  logic [31:0] mem [32];
  int checks = 0, errors = 0;

  regbank_register_file dut (
    .clock(clock), .reset(reset), .regWrite(regWrite),
    .readReg1(readReg1), .readReg2(readReg2), .writeReg(writeReg),
    .writeData(writeData), .readData1(readData1), .readData2(readData2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1, r2;
    logic [31:0] e1, e2;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (regWrite && writeReg == idx) return writeData;
    return mem[idx];
  endfunction

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    regWrite = we; writeReg = wr; writeData = wd; readReg1 = r1; readReg2 = r2;
  endtask

  task automatic tick;
    @(posedge clock);
    if (reset && regWrite && writeReg != 0) mem[writeReg] = writeData;
    @(negedge clock);
  endtask

  task automatic clear_model;
    foreach (mem[k]) mem[k] = 32'h0;
  endtask

  initial begin
    clear_model();
    tbl[0] = '{1'b1, 5'd1, 32'hAAAAAAAA, 5'd1, 5'd0, 32'hAAAAAAAA, 32'h00000000};
    tbl[1] = '{1'b1, 5'd2, 32'h55555555, 5'd2, 5'd1, 32'h55555555, 32'hAAAAAAAA};
    tbl[2] = '{1'b0, 5'd2, 32'hDEADBEEF, 5'd2, 5'd1, 32'h55555555, 32'hAAAAAAAA};
    tbl[3] = '{1'b0, 5'd1, 32'h12345678, 5'd1, 5'd1, 32'hAAAAAAAA, 32'hAAAAAAAA};
    tbl[4] = '{1'b1, 5'd1, 32'h0BADF00D, 5'd1, 5'd1, 32'h0BADF00D, 32'h0BADF00D};
    tbl[5] = '{1'b1, 5'd1, 32'hCAFEBABE, 5'd1, 5'd2, 32'hCAFEBABE, 32'h55555555};
    tbl[6] = '{1'b0, 5'd0, 32'h00000000, 5'd1, 5'd1, 32'hCAFEBABE, 32'hCAFEBABE};
    tbl[7] = '{1'b1, 5'd1, 32'hAAAAAAAA, 5'd0, 5'd3, 32'h00000000, 32'h00000000};
    tbl[8] = '{1'b0, 5'd0, 32'h00000000, 5'd1, 5'd2, 32'hAAAAAAAA, 32'h55555555};

    #1 chk("reset_rd1", readData1, 32'h0);
    @(negedge clock);
    reset = 1;
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i); readReg2 = 5'(31 - i);
      #1;
      chk($sformatf("after_reset_rd1_r%0d", i), readData1, 32'h0);
      chk($sformatf("after_reset_rd2_r%0d", 31 - i), readData2, 32'h0);
    end
    @(negedge clock);

    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1 chk("wr_zero_before", readData1, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1 chk("wr_zero_after", readData1, 32'h0);
    @(negedge clock);

    for (int v = 0; v < 9; v++) begin
      drive(tbl[v].we, tbl[v].wr, tbl[v].wd, tbl[v].r1, tbl[v].r2);
      #1;
      chk($sformatf("vec%0d_rd1", v), readData1, tbl[v].e1);
      chk($sformatf("vec%0d_rd2", v), readData2, tbl[v].e2);
      tick();
    end

    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    #2 reset = 0;
    #1;
    chk("rst_mid_rd1", readData1, 32'h0);
    chk("rst_mid_rd2", readData2, 32'h0);
    clear_model();
    drive(1'b1, 5'd3, 32'h00000077, 5'd3, 5'd1);
    #1;
    chk("rst_bypass_rd1", readData1, 32'h00000077);
    chk("rst_bypass_rd2", readData2, 32'h0);
    tick();
    reset = 1;
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd1);
    #1;
    chk("rst_write_blocked", readData1, 32'h0);
    chk("rst_reg1_cleared", readData2, 32'h0);
    @(negedge clock);

    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), {5'(i), 27'h0} ^ 32'h12345678, 5'd0, 5'(i));
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1 chk("sweep_r0", readData1, 32'h0);
    for (int i = 1; i < 32; i++) begin
      readReg1 = 5'(i); readReg2 = 5'(32 - i);
      #1;
      chk($sformatf("sweep_rd1_r%0d", i), readData1, {5'(i), 27'h0} ^ 32'h12345678);
      chk($sformatf("sweep_rd2_r%0d", 32 - i), readData2, {5'(32 - i), 27'h0} ^ 32'h12345678);
    end
    @(negedge clock);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 0;
        clear_model();
      end else reset = 1;
      drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            ($urandom_range(0, 3) == 0) ? writeReg : 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) readReg2 = writeReg;
      #1;
      chk($sformatf("rand%0d_rd1", n), readData1, model_rd(readReg1));
      chk($sformatf("rand%0d_rd2", n), readData2, model_rd(readReg2));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
